// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the single-port memory arbiter slice:
//   state_t     - sequencing FSM encoding (IDLE / ACCESS / DONE)
//   PORT_FETCH  - index of requester 0 (instruction fetch)
//   PORT_DATA   - index of requester 1 (load/store data)
//   cnt_width() - width of the access-latency down-counter
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  // The counter holds values 0..lat-1; keep at least one bit so a latency of
  // one still yields a legal vector.
  function automatic int cnt_width(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the two requester handshakes and the single memory port.
//   Port 0 (fetch): req0, we0, addr0, wdata0 -> gnt0, rvalid0, rdata0
//   Port 1 (data) : req1, we1, addr1, wdata1 -> gnt1, rvalid1, rdata1
//   Memory        : mem_en, mem_we, mem_addr, mem_wdata -> mem_rdata
// Modports:
//   slave  - the arbiter's view (requests in, grants/memory command out)
//   master - the surrounding system (requesters and memory)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              rvalid0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata1;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, we0, addr0, wdata0,
    output gnt0, rvalid0, rdata0,
    input  req1, we1, addr1, wdata1,
    output gnt1, rvalid1, rdata1,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req0, we0, addr0, wdata0,
    input  gnt0, rvalid0, rdata0,
    output req1, we1, addr1, wdata1,
    input  gnt1, rvalid1, rdata1,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
// Combinational winner select between the fetch and data requesters.
// Build option: MEM_ARB_ROUND_ROBIN_EN
//   defined   - a tie goes to the port that did not win most recently
//   undefined - a tie always goes to the data port (fixed priority)
// A single request always wins regardless of the build.
// Ports:
//   i_req0, i_req1 - pending requests
//   i_last_win     - most recent winner (round-robin build only)
//   o_any          - at least one request pending
//   o_win          - index of the selected port
// -----------------------------------------------------------------------------
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic i_last_win,
`endif
  output logic o_any,
  output logic o_win
);

  logic w_tie_win;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  assign w_tie_win = ~i_last_win;
`else
  // Data accesses must never stall behind instruction fetch.
  assign w_tie_win = PORT_DATA;
`endif

  always_comb begin
    o_any = i_req0 | i_req1;
    o_win = PORT_DATA;
    if (i_req0 && i_req1) begin
      o_win = w_tie_win;
    end else if (i_req0) begin
      o_win = PORT_FETCH;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory port between instruction fetch (port 0) and load/store
// (port 1). A request is sampled on the arbitrating edge, acknowledged with a
// one-cycle gnt, then the memory is enabled for MEM_LATENCY cycles and the
// result is returned with a one-cycle rvalid on the winning port.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking
// (default build: fixed priority, data port first).
// Ports:
//   clk     - system clock, rising edge
//   reset_n - asynchronous active-low reset; aborts any access in flight
//   bus     - mem_port_arbiter_if.slave (requester handshakes + memory port)
// Parameters: ADDR_W, DATA_W, MEM_LATENCY (>= 1).
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  mem_port_arbiter_if.slave   bus
);

  localparam int CNT_W = cnt_width(MEM_LATENCY);

  if (MEM_LATENCY < 1) begin : g_bad_latency
    $error("mem_port_arbiter: MEM_LATENCY must be at least 1");
  end

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_win;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_gnt0;
  logic              r_gnt1;
  logic              r_rvalid0;
  logic              r_rvalid1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic              r_mem_en;

  logic              w_any;
  logic              w_win;
  logic              w_req_we;
  logic [ADDR_W-1:0] w_req_addr;
  logic [DATA_W-1:0] w_req_wdata;
  logic [DATA_W-1:0] w_rsp_data;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic              r_last_win;

  arb_pick u_pick (
    .i_req0     (bus.req0),
    .i_req1     (bus.req1),
    .i_last_win (r_last_win),
    .o_any      (w_any),
    .o_win      (w_win)
  );

  // Starts at the data port so the first tie goes to fetch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_win <= PORT_DATA;
    end else if ((r_state != ACCESS) && w_any) begin
      r_last_win <= w_win;
    end
  end
`else
  arb_pick u_pick (
    .i_req0 (bus.req0),
    .i_req1 (bus.req1),
    .o_any  (w_any),
    .o_win  (w_win)
  );
`endif

  assign w_req_we    = (w_win == PORT_DATA) ? bus.we1    : bus.we0;
  assign w_req_addr  = (w_win == PORT_DATA) ? bus.addr1  : bus.addr0;
  assign w_req_wdata = (w_win == PORT_DATA) ? bus.wdata1 : bus.wdata0;

  // Writes complete with a zero data word rather than whatever the memory
  // happens to drive.
  assign w_rsp_data  = r_we ? '0 : bus.mem_rdata;

  // Sequencer: IDLE/DONE arbitrate, ACCESS holds mem_en for MEM_LATENCY cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_win     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
      r_mem_en  <= 1'b0;
    end else begin
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (w_any) begin
            r_win    <= w_win;
            r_we     <= w_req_we;
            r_addr   <= w_req_addr;
            r_wdata  <= w_req_wdata;
            r_cnt    <= CNT_W'(MEM_LATENCY - 1);
            r_gnt0   <= (w_win == PORT_FETCH);
            r_gnt1   <= (w_win == PORT_DATA);
            r_mem_en <= 1'b1;
            r_state  <= ACCESS;
          end else begin
            r_state  <= IDLE;
          end
        end
        ACCESS: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            // Last enabled cycle: memory data is valid now.
            r_mem_en <= 1'b0;
            if (r_win == PORT_DATA) begin
              r_rdata1  <= w_rsp_data;
              r_rvalid1 <= 1'b1;
            end else begin
              r_rdata0  <= w_rsp_data;
              r_rvalid0 <= 1'b1;
            end
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt0      = r_gnt0;
  assign bus.gnt1      = r_gnt1;
  assign bus.rvalid0   = r_rvalid0;
  assign bus.rvalid1   = r_rvalid1;
  assign bus.rdata0    = r_rdata0;
  assign bus.rdata1    = r_rdata1;
  assign bus.mem_en    = r_mem_en;
  // Address and write data keep their last values between accesses.
  assign bus.mem_we    = r_mem_en & r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with MEM_LATENCY = 3. Stimulus pushes
// the expected grant/response (port, cycle, data) into queues; a monitor pops
// and compares whenever the DUT raises gnt or rvalid. The memory model returns
// 0x2402_0005 at 0x40, written data where written, else {16'hC0DE, addr[15:0]}.
// Build option: MEM_ARB_ROUND_ROBIN_EN switches the expected tie order.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 3;

  typedef struct { int port; int cyc; } gexp_t;
  typedef struct { int port; logic [31:0] data; int cyc; } rexp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  gexp_t exp_gnt[$];
  rexp_t exp_rsp[$];

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .MEM_LATENCY (LAT)
  ) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- memory model ----------------
  logic [31:0] wmem [256];
  bit          wvld [256];
  logic [7:0]  midx;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a == 32'h40) ? 32'h2402_0005 : {16'hC0DE, a[15:0]};
  endfunction

  assign midx = bus.mem_addr[9:2];
  assign bus.mem_rdata = !bus.mem_en ? 32'h0 :
                         (wvld[midx] ? wmem[midx] : init_word(bus.mem_addr));

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) begin
      wmem[midx] <= bus.mem_wdata;
      wvld[midx] <= 1'b1;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic proto_fail(input string nm, input string detail);
    miscompares++;
    $display("FAIL %s: %s (cycle %0d)", nm, detail, cyc);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt0"},      64'(bus.gnt0),      64'h0);
    chk({tag, "_gnt1"},      64'(bus.gnt1),      64'h0);
    chk({tag, "_rvalid0"},   64'(bus.rvalid0),   64'h0);
    chk({tag, "_rvalid1"},   64'(bus.rvalid1),   64'h0);
    chk({tag, "_rdata0"},    64'(bus.rdata0),    64'h0);
    chk({tag, "_rdata1"},    64'(bus.rdata1),    64'h0);
    chk({tag, "_mem_en"},    64'(bus.mem_en),    64'h0);
    chk({tag, "_mem_we"},    64'(bus.mem_we),    64'h0);
    chk({tag, "_mem_addr"},  64'(bus.mem_addr),  64'h0);
    chk({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'h0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    bit          outst [2];
    int          run;
    int          p;
    logic [31:0] last_rd0;
    logic [31:0] last_rd1;
    gexp_t       g;
    rexp_t       r;
    outst[0] = 0; outst[1] = 0; run = 0; last_rd0 = '0; last_rd1 = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        outst[0] = 0; outst[1] = 0; run = 0; last_rd0 = '0; last_rd1 = '0;
      end else begin
        if (bus.gnt0 && bus.gnt1)
          proto_fail("both_gnt", "gnt0=1 gnt1=1, required at most one");
        if (bus.rvalid0 && bus.rvalid1)
          proto_fail("both_rvalid", "rvalid0=1 rvalid1=1, required at most one");
        if (!bus.mem_en && bus.mem_we)
          proto_fail("mem_we_idle", "mem_we=1 with mem_en=0, required 0");
        if (!bus.rvalid0 && bus.rdata0 !== last_rd0)
          proto_fail("rdata0_hold", $sformatf("rdata0=%0h, required %0h", bus.rdata0, last_rd0));
        if (!bus.rvalid1 && bus.rdata1 !== last_rd1)
          proto_fail("rdata1_hold", $sformatf("rdata1=%0h, required %0h", bus.rdata1, last_rd1));

        if (bus.gnt0 || bus.gnt1) begin
          p = bus.gnt1 ? 1 : 0;
          if (exp_gnt.size() == 0) begin
            proto_fail("unexpected_gnt", $sformatf("gnt on port %0d, required none", p));
          end else begin
            g = exp_gnt.pop_front();
            chk("gnt_port", 64'(p), 64'(g.port));
            chk("gnt_cycle", 64'(cyc), 64'(g.cyc));
          end
          if (outst[p])
            proto_fail("gnt_before_rvalid", $sformatf("second gnt on port %0d, required rvalid first", p));
          outst[p] = 1;
        end

        if (bus.rvalid0 || bus.rvalid1) begin
          p = bus.rvalid1 ? 1 : 0;
          if (exp_rsp.size() == 0) begin
            proto_fail("unexpected_rvalid", $sformatf("rvalid on port %0d, required none", p));
          end else begin
            r = exp_rsp.pop_front();
            chk("rsp_port", 64'(p), 64'(r.port));
            chk("rsp_cycle", 64'(cyc), 64'(r.cyc));
            chk("rsp_data", 64'(p == 1 ? bus.rdata1 : bus.rdata0), 64'(r.data));
          end
          if (!outst[p])
            proto_fail("rvalid_without_gnt", $sformatf("rvalid on port %0d, required a gnt first", p));
          outst[p] = 0;
          if (p == 1) last_rd1 = bus.rdata1; else last_rd0 = bus.rdata0;
        end

        if (bus.mem_en) begin
          run++;
        end else if (run != 0) begin
          chk("mem_en_len", 64'(run), 64'(LAT));
          run = 0;
        end
      end
    end
  end

  // ---------------- requester driving ----------------
  task automatic set_req(input int p, input logic rq, input logic w,
                         input logic [31:0] ad, input logic [31:0] wd);
    if (p == 0) begin
      bus.req0 = rq; bus.we0 = w; bus.addr0 = ad; bus.wdata0 = wd;
    end else begin
      bus.req1 = rq; bus.we1 = w; bus.addr1 = ad; bus.wdata1 = wd;
    end
  endtask

  function automatic bit hit(input int p, input bit rv);
    if (rv) return (p == 1) ? bus.rvalid1 : bus.rvalid0;
    return (p == 1) ? bus.gnt1 : bus.gnt0;
  endfunction

  task automatic wait_sig(input int p, input bit rv);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!hit(p, rv) && n < 64);
    if (!hit(p, rv))
      proto_fail(rv ? "rvalid_timeout" : "gnt_timeout",
                 $sformatf("port %0d waited %0d cycles, required a response", p, n));
  endtask

  // Back-to-back requests: the next one is raised in the rvalid cycle.
  // Fields are scrambled after gnt to show they are not resampled.
  task automatic run_port(input int p, input int n, input logic w,
                          input logic [31:0] a0, input logic [31:0] wd);
    for (int k = 0; k < n; k++) begin
      set_req(p, 1'b1, w, a0 + 32'(4 * k), wd);
      wait_sig(p, 1'b0);
      set_req(p, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h5A5A_5A5A);
      wait_sig(p, 1'b1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int          c;
    int          p;
    int          k0;
    int          k1;
    logic [31:0] a;

    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    #2 reset_n = 1'b0;
    idle(3);
    check_all_zero("rst");
    reset_n = 1'b1;
    idle(2);

    // Single fetch read of 0x40.
    c = cyc;
    exp_gnt.push_back('{0, c + 1});
    exp_rsp.push_back('{0, 32'h2402_0005, c + 1 + LAT});
    run_port(0, 1, 1'b0, 32'h40, 32'h0);
    idle(2);

    // Data port: write 0x100 then read it back, back-to-back.
    c = cyc;
    exp_gnt.push_back('{1, c + 1});
    exp_rsp.push_back('{1, 32'h0, c + 1 + LAT});
    exp_gnt.push_back('{1, c + 2 + LAT});
    exp_rsp.push_back('{1, 32'hDEAD_BEEF, c + 2 + 2 * LAT});
    run_port(1, 1, 1'b1, 32'h100, 32'hDEAD_BEEF);
    run_port(1, 1, 1'b0, 32'h100, 32'h0);
    idle(2);

    // Simultaneous requests from IDLE.
    c = cyc;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_gnt.push_back('{0, c + 1});
    exp_rsp.push_back('{0, 32'h2402_0005, c + 1 + LAT});
    exp_gnt.push_back('{1, c + 2 + LAT});
    exp_rsp.push_back('{1, 32'hDEAD_BEEF, c + 2 + 2 * LAT});
`else
    exp_gnt.push_back('{1, c + 1});
    exp_rsp.push_back('{1, 32'hDEAD_BEEF, c + 1 + LAT});
    exp_gnt.push_back('{0, c + 2 + LAT});
    exp_rsp.push_back('{0, 32'h2402_0005, c + 2 + 2 * LAT});
`endif
    fork
      run_port(0, 1, 1'b0, 32'h40, 32'h0);
      run_port(1, 1, 1'b0, 32'h100, 32'h0);
    join
    idle(2);

    // Eight continuously contended requests (four per port).
    c = cyc; k0 = 0; k1 = 0;
    for (int i = 0; i < 8; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      p = i % 2;
`else
      p = (i < 4) ? 1 : 0;
`endif
      if (p == 1) begin
        a = 32'h300 + 32'(4 * k1); k1++;
      end else begin
        a = 32'h200 + 32'(4 * k0); k0++;
      end
      exp_gnt.push_back('{p, c + 1 + i * (LAT + 1)});
      exp_rsp.push_back('{p, {16'hC0DE, a[15:0]}, c + 1 + LAT + i * (LAT + 1)});
    end
    fork
      run_port(0, 4, 1'b0, 32'h200, 32'h0);
      run_port(1, 4, 1'b0, 32'h300, 32'h0);
    join
    idle(2);

    // Continuous fetch stream: one rvalid0 every LAT+1 cycles.
    c = cyc;
    exp_gnt.push_back('{0, c + 1});
    exp_rsp.push_back('{0, 32'hC0DE_0280, c + 1 + LAT});
    exp_gnt.push_back('{0, c + 1 + (LAT + 1)});
    exp_rsp.push_back('{0, 32'hC0DE_0284, c + 1 + LAT + (LAT + 1)});
    exp_gnt.push_back('{0, c + 1 + 2 * (LAT + 1)});
    exp_rsp.push_back('{0, 32'hC0DE_0288, c + 1 + LAT + 2 * (LAT + 1)});
    run_port(0, 3, 1'b0, 32'h280, 32'h0);
    idle(2);

    // Reset in the second ACCESS cycle aborts the access.
    c = cyc;
    exp_gnt.push_back('{0, c + 1});
    set_req(0, 1'b1, 1'b0, 32'h44, 32'h0);
    wait_sig(0, 1'b0);
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(1);
    chk("abort_mem_en_before", 64'(bus.mem_en), 64'h1);
    reset_n = 1'b0;
    #1;
    check_all_zero("abort");
    idle(3);
    reset_n = 1'b1;
    idle(2);

    // Normal read after the aborted access.
    c = cyc;
    exp_gnt.push_back('{0, c + 1});
    exp_rsp.push_back('{0, 32'h2402_0005, c + 1 + LAT});
    run_port(0, 1, 1'b0, 32'h40, 32'h0);
    idle(6);

    chk("gnt_queue_drained", 64'(exp_gnt.size()), 64'h0);
    chk("rsp_queue_drained", 64'(exp_rsp.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port between two requesters: instruction fetch (port 0, IFU) and load/store data access (port 1).
- Serialises their requests, sequences a fixed-latency memory access, and routes read data or a write-completion acknowledge back to the requester that won.
- Sits between the IFU/LSU and the memory module. It replaces the dual-port assumption so the processor can run against a single-ported memory.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port.
- DATA_W, 32, data width.
- MEM_LATENCY, 1, cycles that mem_en is held per access; mem_rdata is valid on the last of these cycles. Must be at least 1; 0 is illegal and must trigger an elaboration error.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req0  in  1  port 0 (fetch) request; held until gnt0.
- we0  in  1  port 0 write enable; normally 0 for fetch.
- addr0  in  ADDR_W  port 0 address.
- wdata0  in  DATA_W  port 0 write data.
- gnt0  out  1  one-cycle pulse: port 0 request accepted and latched.
- rvalid0  out  1  one-cycle pulse: port 0 access complete.
- rdata0  out  DATA_W  port 0 read data, valid while rvalid0 is high.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same meanings for port 1 (data).
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Clock and reset: one clock, clk. Reset is reset_n, asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, latched request registers 0, last-winner register = port 1.
- States are IDLE, ACCESS and DONE.
- IDLE and DONE both arbitrate. On a clock edge with req0 or req1 high:
  - pick the winner;
  - latch its we/addr/wdata and the winner index;
  - load cnt = MEM_LATENCY-1;
  - go to ACCESS;
  - assert the winner's gnt for exactly the next cycle.
- With no request, IDLE stays in IDLE and DONE goes to IDLE.
- ACCESS: mem_en=1, with mem_we/mem_addr/mem_wdata driven from the latched registers.
  - When cnt≠0: decrement cnt and stay in ACCESS.
  - When cnt=0: capture mem_rdata (reads) or 0 (writes) into the winner's rdata, then go to DONE.
- Outside ACCESS: mem_en=0 and mem_we=0; mem_addr and mem_wdata hold their last values.
- DONE: the winner's rvalid is 1 for exactly this cycle. rdata holds its value until the next completion on that port.
- Latency:
  - Request sampled at edge k → gnt high in cycle k+1 → rvalid high in cycle k+MEM_LATENCY+1.
  - Back-to-back requests sustain one access every MEM_LATENCY+1 cycles.
- Requester rules:
  - A requester keeps req and its request fields stable until it sees gnt; the arbiter samples them only at the winning edge.
  - After gnt, inputs may change; req may be reasserted immediately for a new request.
  - A requester must not issue its next request before its rvalid. Violations are unsupported; the bench flags them.
- Arbitration: fixed priority, port 1 beats port 0 (data access must not stall behind fetch). A losing request stays pending and is untouched.
- gnt0 and gnt1 are never both high; rvalid0 and rvalid1 are never both high.
- Reset mid-access aborts immediately:
  - mem_en drops asynchronously;
  - no rvalid is produced;
  - the state returns to IDLE.
  A write already presented to memory may or may not have completed; this is undefined.
- Requests on ports whose req is low are ignored regardless of we/addr.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. On simultaneous requests, grant the port that did not win most recently. The last-winner register updates at each grant; its reset value is port 1, so port 0 wins the first tie.
- Undefined: fixed priority, port 1 first. The last-winner register is not implemented.
- Single-request behaviour is identical in both builds.

Decomposition:
- Shared header/package mem_arb_pkg holds:
  - state encodings: IDLE=2'd0, ACCESS=2'd1, DONE=2'd2;
  - port index constants: PORT_FETCH=0, PORT_DATA=1.
- One natural sub-module, arb_pick: combinational winner select from req0, req1 and last_winner, covering both the fixed and round-robin variants under the macro. All sequencing stays in mem_port_arbiter.

Test Plan:
- Single read, MEM_LATENCY=1: req0 with addr0=0x40, memory word 0x2402_0005 → gnt0 in cycle 1, mem_en in cycle 1, rvalid0 in cycle 2, rdata0=0x2402_0005; gnt1 and rvalid1 stay low.
- Write then read, port 1: we1=1, addr1=0x100, wdata1=0xDEAD_BEEF, then a read of 0x100 → memory stores 0xDEAD_BEEF; first rvalid1 carries rdata1=0; second rvalid1 carries 0xDEAD_BEEF.
- Simultaneous req0 and req1 in IDLE:
  - fixed build: gnt1 first, gnt0 exactly MEM_LATENCY+1 cycles later;
  - round-robin build: gnt0 first, then gnt1; over 8 continuous contended requests, grants alternate.
- MEM_LATENCY=3: single read → mem_en high for exactly 3 cycles; rvalid 4 cycles after the sampled edge; continuous port 0 requests give one rvalid0 every 4 cycles.
- Reset during ACCESS (MEM_LATENCY=3, reset_n low in the 2nd ACCESS cycle) → mem_en low asynchronously, no rvalid, all outputs 0; after release, a new req0 completes normally.
- Protocol checks throughout: never both gnts or both rvalids high; every gnt followed by exactly one matching rvalid.
